// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC1 = 3'd1,
    ST_ACC2 = 3'd2,
    ST_CAP  = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Right-justified byte mask for an access size; illegal size touches no byte.
  function automatic logic [3:0] size_mask(input lsu_size_e size);
    case (size)
      SZ_B:    size_mask = 4'h1;
      SZ_H:    size_mask = 4'h3;
      SZ_W:    size_mask = 4'hF;
      default: size_mask = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte-enable mask, store-data shift, split and
// misalignment detection, and the load extract / sign-extend path.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [7:0]  m8_o,
  output logic [63:0] w64_o,
  output logic        split_o,
  output logic        misaligned_o,
  output logic [31:0] rdata_o
);

  lsu_size_e   size;
  logic [31:0] r32;

  assign size         = lsu_size_e'(size_i);
  assign m8_o         = {4'b0000, size_mask(size)} << off_i;
  assign split_o      = |m8_o[7:4];
  assign misaligned_o = ((size == SZ_H) && (off_i == 2'd3)) ||
                        ((size == SZ_W) && (off_i != 2'd0));
  assign w64_o        = {32'b0, wdata_i} << {off_i, 3'b000};
  // Bring the addressed bytes of the two-word window down to bit 0.
  assign r32          = 32'({hi_i, lo_i} >> {off_i, 3'b000});

  // Trim the loaded value to the access size and extend it to 32 bits.
  always_comb begin
    rdata_o = r32;
    case (size)
      SZ_B:    rdata_o = uns_i ? {24'b0, r32[7:0]}  : {{24{r32[7]}},  r32[7:0]};
      SZ_H:    rdata_o = uns_i ? {16'b0, r32[15:0]} : {{16{r32[15]}}, r32[15:0]};
      default: rdata_o = r32;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: accepts one request at a time, issues one or two
// word-aligned memory accesses, and returns a single response per request.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter logic ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w_en,
  output logic        mem_r_en,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        two_q, two_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_hold_q, addr_hold_d;
  logic [31:0] wdata_hold_q, wdata_hold_d;

  logic        idle;
  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic [31:0] al_lo;
  logic [7:0]  m8;
  logic [63:0] w64;
  logic        split;
  logic        misaligned;
  logic [31:0] ext_rdata;
  logic        accept_err;
  logic [31:0] base;

  // While idle the aligner judges the incoming request; afterwards it works
  // only from the registered copy.
  assign idle    = (state_q == ST_IDLE);
  assign al_size = idle ? req_size : size_q;
  assign al_off  = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_lo   = two_q ? lo_q : mem_rdata;
  assign base    = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .size_i       (al_size),
    .off_i        (al_off),
    .uns_i        (uns_q),
    .wdata_i      (wdata_q),
    .lo_i         (al_lo),
    .hi_i         (mem_rdata),
    .m8_o         (m8),
    .w64_o        (w64),
    .split_o      (split),
    .misaligned_o (misaligned),
    .rdata_o      (ext_rdata)
  );

  assign accept_err = (req_size == SZ_ILL) || (!ALLOW_MISALIGNED && misaligned);

  assign req_ready = idle && rst_n;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

  // Next-state and memory-port decode; the port idles on the held address/data.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    two_d          = two_q;
    lo_d           = lo_q;
    rdata_d        = rdata_q;
    addr_hold_d    = addr_hold_q;
    wdata_hold_d   = wdata_hold_q;
    mem_addr       = addr_hold_q;
    mem_wdata      = wdata_hold_q;
    mem_byteenable = 4'h0;
    mem_r_en       = 1'b0;
    mem_w_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = accept_err;
          two_d   = 1'b0;
          rdata_d = 32'h0;
          state_d = accept_err ? ST_RESP : ST_ACC1;
        end
      end
      ST_ACC1: begin
        mem_addr       = base;
        mem_byteenable = m8[3:0];
        mem_r_en       = !we_q;
        mem_w_en       = we_q;
        addr_hold_d    = base;
        if (we_q) begin
          mem_wdata    = w64[31:0];
          wdata_hold_d = w64[31:0];
        end
        if (split)     state_d = ST_ACC2;
        else if (we_q) state_d = ST_RESP;
        else           state_d = ST_CAP;
      end
      ST_ACC2: begin
        mem_addr       = base + 32'd4;
        mem_byteenable = m8[7:4];
        mem_r_en       = !we_q;
        mem_w_en       = we_q;
        addr_hold_d    = base + 32'd4;
        if (we_q) begin
          mem_wdata    = w64[63:32];
          wdata_hold_d = w64[63:32];
        end
        lo_d    = mem_rdata;
        two_d   = 1'b1;
        state_d = we_q ? ST_RESP : ST_CAP;
      end
      ST_CAP: begin
        rdata_d = ext_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      two_q        <= 1'b0;
      lo_q         <= 32'h0;
      rdata_q      <= 32'h0;
      addr_hold_q  <= 32'h0;
      wdata_hold_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      two_q        <= two_d;
      lo_q         <= lo_d;
      rdata_q      <= rdata_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: a vector table for single requests
// plus hand-written sequences for reset, idle hold and the no-misalign build.
module tb_lsu_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_w_en, mem_r_en;
  logic [3:0]  mem_byteenable;

  logic        b_req_valid, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h0;
  logic        b_mem_w_en, b_mem_r_en;
  logic [3:0]  b_mem_byteenable;

  always #5 clk = ~clk;

  lsu_mem_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_byteenable(mem_byteenable),
    .mem_rdata(mem_rdata)
  );

  lsu_mem_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_w_en(b_mem_w_en), .mem_r_en(b_mem_r_en), .mem_byteenable(b_mem_byteenable),
    .mem_rdata(b_mem_rdata)
  );

  // Small word memory; the used addresses map to distinct slots.
  logic [31:0] mem_a [0:31];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = 32'h0, bd_data = 32'h0;

  function automatic logic [4:0] idx(input logic [31:0] a);
    return {a[31], a[14:12], a[2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bd_we) mem_a[idx(bd_addr)] <= bd_data;
    else if (mem_w_en) mem_a[idx(mem_addr)] <= merge(mem_a[idx(mem_addr)], mem_wdata, mem_byteenable);
    mem_rdata <= mem_r_en ? mem_a[idx(mem_addr)] : 32'hDEADBEEF;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Trace of one request on DUT A.
  int          tr_lat, tr_n, tr_re, tr_we;
  logic        tr_both, tr_rdy1, tr_after, tr_err;
  logic [31:0] tr_rdata;
  logic [31:0] tr_a [0:1];
  logic [3:0]  tr_b [0:1];
  logic [31:0] tr_w [0:1];

  task automatic run_a(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int g;
    tr_lat = 0; tr_n = 0; tr_re = 0; tr_we = 0; tr_both = 1'b0; tr_rdy1 = 1'b1;
    tr_err = 1'b0; tr_rdata = 32'hX;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 10) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 12 && tr_lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) tr_rdy1 = req_ready;
      if (mem_r_en && mem_w_en) tr_both = 1'b1;
      if (mem_r_en) tr_re++;
      if (mem_w_en) tr_we++;
      if (mem_r_en || mem_w_en) begin
        if (tr_n < 2) begin
          tr_a[tr_n] = mem_addr; tr_b[tr_n] = mem_byteenable; tr_w[tr_n] = mem_wdata;
        end
        tr_n++;
      end
      if (rsp_valid) begin
        tr_lat = n; tr_rdata = rsp_rdata; tr_err = rsp_err;
      end
    end
    @(negedge clk);
    tr_after = rsp_valid;
  endtask

  // One request on DUT B (misaligned accesses rejected).
  int          bt_lat, bt_acc;
  logic        bt_err;
  logic [31:0] bt_rdata;

  task automatic run_b(input logic [1:0] size, input logic [31:0] addr);
    int g;
    bt_lat = 0; bt_acc = 0; bt_err = 1'b0; bt_rdata = 32'hX;
    @(negedge clk);
    b_req_we = 1'b0; b_req_size = size; b_req_unsigned = 1'b0; b_req_addr = addr;
    b_req_wdata = 32'h0; b_req_valid = 1'b1;
    g = 0;
    while (!b_req_ready && g < 10) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    for (int n = 1; n <= 12 && bt_lat == 0; n++) begin
      @(negedge clk);
      if (b_mem_r_en || b_mem_w_en) bt_acc++;
      if (b_rsp_valid) begin bt_lat = n; bt_rdata = b_rsp_rdata; bt_err = b_rsp_err; end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [31:0] pa0, pd0, pa1, pd1;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_nacc;
    logic [31:0] ea1; logic [3:0] eb1; logic [31:0] ew1;
    logic [31:0] ea2; logic [3:0] eb2; logic [31:0] ew2;
    logic [31:0] ca0, cd0, ca1, cd1;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int rsp_seen;
    //           we size   uns addr          wdata          pa0           pd0           pa1           pd1           rdata         err lat nacc ea1           eb1   ew1           ea2           eb2   ew2           ca0           cd0           ca1           cd1
    vecs[0]  = '{0, 2'b10, 0, 32'h00001000, 32'h0,        32'h00001000, 32'h8899AABB, 32'h00001000, 32'h8899AABB, 32'h8899AABB, 0, 3, 1, 32'h00001000, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00001000, 32'h8899AABB, 32'h00001000, 32'h8899AABB};
    vecs[1]  = '{0, 2'b00, 0, 32'h00001003, 32'h0,        32'h00001000, 32'h80123456, 32'h00001000, 32'h80123456, 32'hFFFFFF80, 0, 3, 1, 32'h00001000, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00001000, 32'h80123456, 32'h00001000, 32'h80123456};
    vecs[2]  = '{0, 2'b00, 1, 32'h00001003, 32'h0,        32'h00001000, 32'h80123456, 32'h00001000, 32'h80123456, 32'h00000080, 0, 3, 1, 32'h00001000, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00001000, 32'h80123456, 32'h00001000, 32'h80123456};
    vecs[3]  = '{0, 2'b01, 0, 32'h00001002, 32'h0,        32'h00001000, 32'h80017777, 32'h00001000, 32'h80017777, 32'hFFFF8001, 0, 3, 1, 32'h00001000, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00001000, 32'h80017777, 32'h00001000, 32'h80017777};
    vecs[4]  = '{0, 2'b01, 1, 32'h00001001, 32'h0,        32'h00001000, 32'h12ABCD34, 32'h00001000, 32'h12ABCD34, 32'h0000ABCD, 0, 3, 1, 32'h00001000, 4'h6, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00001000, 32'h12ABCD34, 32'h00001000, 32'h12ABCD34};
    vecs[5]  = '{0, 2'b10, 0, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFC, 32'hBBAA0000, 32'h00000000, 32'h0000DDCC, 32'hDDCCBBAA, 0, 4, 2, 32'hFFFFFFFC, 4'hC, 32'h0,        32'h00000000, 4'h3, 32'h0,        32'hFFFFFFFC, 32'hBBAA0000, 32'h00000000, 32'h0000DDCC};
    vecs[6]  = '{0, 2'b01, 0, 32'h00004003, 32'h0,        32'h00004000, 32'h7F000000, 32'h00004004, 32'h000000FF, 32'hFFFFFF7F, 0, 4, 2, 32'h00004000, 4'h8, 32'h0,        32'h00004004, 4'h1, 32'h0,        32'h00004000, 32'h7F000000, 32'h00004004, 32'h000000FF};
    vecs[7]  = '{1, 2'b10, 0, 32'h00002002, 32'h11223344, 32'h00002000, 32'hAAAAAAAA, 32'h00002004, 32'hBBBBBBBB, 32'h00000000, 0, 3, 2, 32'h00002000, 4'hC, 32'h33440000, 32'h00002004, 4'h3, 32'h00001122, 32'h00002000, 32'h3344AAAA, 32'h00002004, 32'hBBBB1122};
    vecs[8]  = '{1, 2'b00, 0, 32'h00005001, 32'hFFFFFF5A, 32'h00005000, 32'h00000000, 32'h00005000, 32'h00000000, 32'h00000000, 0, 2, 1, 32'h00005000, 4'h2, 32'hFFFF5A00, 32'h0,        4'h0, 32'h0,        32'h00005000, 32'h00005A00, 32'h00005000, 32'h00005A00};
    vecs[9]  = '{1, 2'b01, 0, 32'h00006000, 32'h0000BEEF, 32'h00006000, 32'h12345678, 32'h00006000, 32'h12345678, 32'h00000000, 0, 2, 1, 32'h00006000, 4'h3, 32'h0000BEEF, 32'h0,        4'h0, 32'h0,        32'h00006000, 32'h1234BEEF, 32'h00006000, 32'h1234BEEF};
    vecs[10] = '{1, 2'b00, 0, 32'h00006003, 32'h000000A5, 32'h00006000, 32'h1234BEEF, 32'h00006000, 32'h1234BEEF, 32'h00000000, 0, 2, 1, 32'h00006000, 4'h8, 32'hA5000000, 32'h0,        4'h0, 32'h0,        32'h00006000, 32'hA534BEEF, 32'h00006000, 32'hA534BEEF};
    vecs[11] = '{0, 2'b11, 0, 32'h00003000, 32'h0,        32'h00003000, 32'hCAFEF00D, 32'h00003000, 32'hCAFEF00D, 32'h00000000, 1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00003000, 32'hCAFEF00D, 32'h00003000, 32'hCAFEF00D};
    vecs[12] = '{1, 2'b11, 0, 32'h00003000, 32'h01020304, 32'h00003000, 32'hCAFEF00D, 32'h00003000, 32'hCAFEF00D, 32'h00000000, 1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00003000, 32'hCAFEF00D, 32'h00003000, 32'hCAFEF00D};
    vecs[13] = '{1, 2'b01, 0, 32'h00004003, 32'h0000BEEF, 32'h00004000, 32'h00000000, 32'h00004004, 32'hFFFFFFFF, 32'h00000000, 0, 3, 2, 32'h00004000, 4'h8, 32'hEF000000, 32'h00004004, 4'h1, 32'h000000BE, 32'h00004000, 32'hEF000000, 32'h00004004, 32'hFFFFFFBE};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst/req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst/rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst/rsp_rdata", rsp_rdata, 32'h0);
    chk("rst/rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst/r_en_w_en", {30'b0, mem_r_en, mem_w_en}, 32'h0);
    chk("rst/addr", mem_addr, 32'h0);
    chk("rst/wdata", mem_wdata, 32'h0);
    chk("rst/be", {28'b0, mem_byteenable}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/ready_after", {31'b0, req_ready}, 32'h1);

    // Table-driven single requests
    for (int i = 0; i < 14; i++) begin
      preload(vecs[i].pa0, vecs[i].pd0);
      preload(vecs[i].pa1, vecs[i].pd1);
      run_a(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d/latency", i), tr_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d/rdata", i), tr_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d/err", i), {31'b0, tr_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d/naccess", i), tr_n, vecs[i].exp_nacc);
      chk($sformatf("v%0d/rd_count", i), tr_re, vecs[i].we ? 0 : vecs[i].exp_nacc);
      chk($sformatf("v%0d/wr_count", i), tr_we, vecs[i].we ? vecs[i].exp_nacc : 0);
      chk($sformatf("v%0d/rd_and_wr", i), {31'b0, tr_both}, 32'h0);
      chk($sformatf("v%0d/busy_ready", i), {31'b0, tr_rdy1}, 32'h0);
      chk($sformatf("v%0d/rsp_pulse", i), {31'b0, tr_after}, 32'h0);
      if (vecs[i].exp_nacc >= 1) begin
        chk($sformatf("v%0d/addr1", i), tr_a[0], vecs[i].ea1);
        chk($sformatf("v%0d/be1", i), {28'b0, tr_b[0]}, {28'b0, vecs[i].eb1});
        if (vecs[i].we) chk($sformatf("v%0d/wdata1", i), tr_w[0], vecs[i].ew1);
      end
      if (vecs[i].exp_nacc == 2) begin
        chk($sformatf("v%0d/addr2", i), tr_a[1], vecs[i].ea2);
        chk($sformatf("v%0d/be2", i), {28'b0, tr_b[1]}, {28'b0, vecs[i].eb2});
        if (vecs[i].we) chk($sformatf("v%0d/wdata2", i), tr_w[1], vecs[i].ew2);
      end
      chk($sformatf("v%0d/mem0", i), mem_a[idx(vecs[i].ca0)], vecs[i].cd0);
      chk($sformatf("v%0d/mem1", i), mem_a[idx(vecs[i].ca1)], vecs[i].cd1);
    end

    // Idle port holds the last split-store access (SH 0x4003) with no enables
    chk("idle/addr", mem_addr, 32'h00004004);
    chk("idle/wdata", mem_wdata, 32'h000000BE);
    chk("idle/be", {28'b0, mem_byteenable}, 32'h0);
    chk("idle/en", {30'b0, mem_r_en, mem_w_en}, 32'h0);

    // Reset during the second half of a split store
    preload(32'h00007000, 32'h00000000);
    preload(32'h00007004, 32'h55555555);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h00007002; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mrst/acc1_w_en", {31'b0, mem_w_en}, 32'h1);
    @(posedge clk);
    #1;
    chk("mrst/acc2_w_en", {31'b0, mem_w_en}, 32'h1);
    chk("mrst/acc2_addr", mem_addr, 32'h00007004);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst/w_en_drop", {31'b0, mem_w_en}, 32'h0);
    chk("mrst/be_drop", {28'b0, mem_byteenable}, 32'h0);
    chk("mrst/ready_low", {31'b0, req_ready}, 32'h0);
    rsp_seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) rsp_seen++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (rsp_valid) rsp_seen++; end
    chk("mrst/no_rsp", rsp_seen, 0);
    chk("mrst/ready_high", {31'b0, req_ready}, 32'h1);
    chk("mrst/mem_lo", mem_a[idx(32'h00007000)], 32'h33440000);
    chk("mrst/mem_hi_untouched", mem_a[idx(32'h00007004)], 32'h55555555);
    preload(32'h00001000, 32'h0A0B0C0D);
    run_a(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0);
    chk("mrst/lw_latency", tr_lat, 3);
    chk("mrst/lw_rdata", tr_rdata, 32'h0A0B0C0D);
    chk("mrst/lw_err", {31'b0, tr_err}, 32'h0);

    // Build without misaligned support
    run_b(2'b01, 32'h00003003);
    chk("nomis/lh_latency", bt_lat, 1);
    chk("nomis/lh_err", {31'b0, bt_err}, 32'h1);
    chk("nomis/lh_rdata", bt_rdata, 32'h0);
    chk("nomis/lh_access", bt_acc, 0);
    run_b(2'b10, 32'h00003000);
    chk("nomis/lw_latency", bt_lat, 3);
    chk("nomis/lw_err", {31'b0, bt_err}, 32'h0);
    chk("nomis/lw_access", bt_acc, 1);
    chk("nomis/lw_rdata", bt_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

endmodule
